// File: rtl/mips_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: one-hot phase
// codes, the supported opcodes, ALU/PC select codes and the strobe bundle
// produced by the decoder.
package mips_ctrl_pkg;

   // One-hot phase encoding; the register file keys its read on ST_ID and its
   // write on ST_WB, so these values must stay exactly as listed.
   typedef enum logic [5:0] {
      ST_HALT = 6'b000000,
      ST_IF   = 6'b000001,
      ST_ID   = 6'b000010,
      ST_EX   = 6'b000100,
      ST_MEMW = 6'b001000,
      ST_MEMR = 6'b010000,
      ST_WB   = 6'b100000
   } state_t;

   // Opcodes (IR[31:26]) understood by the sequencer
   localparam logic [5:0] RTYPE   = 6'b000000;
   localparam logic [5:0] LW      = 6'b100011;
   localparam logic [5:0] SW      = 6'b101011;
   localparam logic [5:0] BEQ     = 6'b000100;
   localparam logic [5:0] J       = 6'b000010;
   localparam logic [5:0] ADDI    = 6'b001000;
   localparam logic [5:0] HALT_OP = 6'b111111;

   // ALU operation select
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // PC source select
   localparam logic [1:0] PCSRC_SEQ    = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Every strobe the decoder drives, plus the internal retire pulse
   typedef struct packed {
      logic       mem_req;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       mem_to_reg;
      logic       illegal;
      logic       halted;
      logic       retire;
   } ctrl_t;

   // Opcodes that need an execute phase after decode
   function automatic logic goes_to_ex(input logic [5:0] op);
      logic r;
      case (op)
         RTYPE, LW, SW, BEQ, ADDI: r = 1'b1;
         default:                  r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mips_control_fsm_if.sv
// Instruction/data memory handshake between the control sequencer (master)
// and the memory model or arbiter (slave).
interface mips_control_fsm_if;
   logic mem_req;
   logic mem_ready;
   logic MemRead;
   logic MemWrite;

   modport master (output mem_req, output MemRead, output MemWrite, input mem_ready);
   modport slave  (input mem_req, input MemRead, input MemWrite, output mem_ready);
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational strobe decoder: maps the current phase and the effective
// opcode (raw opcode in ID, latched opcode afterwards) onto the strobe bundle.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t     i_state,
   input  logic [5:0] i_opcode,
   input  logic       i_mem_ready,
   output ctrl_t      o_ctrl
);

   // Moore decode of the phase; IF and MEMW additionally qualify on mem_ready
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         ST_IF: begin
            o_ctrl.mem_req  = 1'b1;
            o_ctrl.mem_read = 1'b1;
            // Load IR and advance PC only in the cycle the fetch completes
            if (i_mem_ready) begin
               o_ctrl.ir_write = 1'b1;
               o_ctrl.pc_write = 1'b1;
               o_ctrl.pc_src   = PCSRC_SEQ;
            end
         end
         ST_ID: begin
            case (i_opcode)
               J: begin
                  o_ctrl.pc_write = 1'b1;
                  o_ctrl.pc_src   = PCSRC_JUMP;
                  o_ctrl.retire   = 1'b1;
               end
               RTYPE, LW, SW, BEQ, ADDI, HALT_OP: ;
               default: o_ctrl.illegal = 1'b1;
            endcase
         end
         ST_EX: begin
            case (i_opcode)
               RTYPE: o_ctrl.alu_op = ALUOP_FUNCT;
               ADDI, LW, SW: begin
                  o_ctrl.alu_src = 1'b1;
                  o_ctrl.alu_op  = ALUOP_ADD;
               end
               BEQ: begin
                  // PC update is gated by zero in the datapath, not here
                  o_ctrl.alu_op        = ALUOP_SUB;
                  o_ctrl.pc_write_cond = 1'b1;
                  o_ctrl.pc_src        = PCSRC_BRANCH;
                  o_ctrl.retire        = 1'b1;
               end
               default: ;
            endcase
         end
         ST_MEMR: begin
            o_ctrl.mem_req  = 1'b1;
            o_ctrl.mem_read = 1'b1;
         end
         ST_MEMW: begin
            o_ctrl.mem_req   = 1'b1;
            o_ctrl.mem_write = 1'b1;
            o_ctrl.retire    = i_mem_ready;
         end
         ST_WB: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.reg_dst    = (i_opcode == RTYPE);
            o_ctrl.mem_to_reg = (i_opcode == LW);
            o_ctrl.retire     = 1'b1;
         end
         ST_HALT: o_ctrl.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle control sequencer for the non-pipelined MIPS core: phase
// register, latched opcode for EX onward, and the retired-instruction counter.
module mips_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               zero,
   mips_control_fsm_if.master mem_if,
   output logic [5:0]         state,
   output logic               RegWrite,
   output logic               RegDst,
   output logic               ALUSrc,
   output logic [1:0]         ALUOp,
   output logic               MemtoReg,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic [1:0]         PCSrc,
   output logic               illegal,
   output logic               halted,
   output logic [CNT_W-1:0]   retired
);

   state_t           r_state;
   state_t           w_next;
   logic [5:0]       r_op_q;
   logic [CNT_W-1:0] r_retired;
   logic [5:0]       w_dec_op;
   ctrl_t            w_ctrl;
   logic             w_unused;

   // zero only matters to the datapath's branch gating
   assign w_unused = zero;

   // ID decides on the live opcode; later phases must ignore IR changes
   assign w_dec_op = (r_state == ST_ID) ? opcode : r_op_q;

   mips_ctrl_decode u_decode (
      .i_state     (r_state),
      .i_opcode    (w_dec_op),
      .i_mem_ready (mem_if.mem_ready),
      .o_ctrl      (w_ctrl)
   );

   // Next-phase selection
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IF:   if (mem_if.mem_ready) w_next = ST_ID;
         ST_ID: begin
            if (goes_to_ex(opcode))      w_next = ST_EX;
            else if (opcode == HALT_OP)  w_next = ST_HALT;
            else                         w_next = ST_IF;
         end
         ST_EX: begin
            case (r_op_q)
               RTYPE, ADDI: w_next = ST_WB;
               LW:          w_next = ST_MEMR;
               SW:          w_next = ST_MEMW;
               default:     w_next = ST_IF;
            endcase
         end
         ST_MEMR: if (mem_if.mem_ready) w_next = ST_WB;
         ST_MEMW: if (mem_if.mem_ready) w_next = ST_IF;
         ST_WB:   w_next = ST_IF;
         ST_HALT: w_next = ST_HALT;
         default: w_next = ST_IF;
      endcase
   end

   // Phase register; reset aborts whatever was in flight
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IF;
      else        r_state <= w_next;
   end

   // Opcode latch on EX entry and retire counter (wraps naturally)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op_q    <= '0;
         r_retired <= '0;
      end else begin
         if (r_state == ST_ID && w_next == ST_EX) r_op_q <= opcode;
         if (w_ctrl.retire) r_retired <= r_retired + CNT_W'(1);
      end
   end

   assign state           = r_state;
   assign retired         = r_retired;
   assign mem_if.mem_req  = w_ctrl.mem_req;
   assign mem_if.MemRead  = w_ctrl.mem_read;
   assign mem_if.MemWrite = w_ctrl.mem_write;
   assign IRWrite         = w_ctrl.ir_write;
   assign PCWrite         = w_ctrl.pc_write;
   assign PCWriteCond     = w_ctrl.pc_write_cond;
   assign PCSrc           = w_ctrl.pc_src;
   assign RegWrite        = w_ctrl.reg_write;
   assign RegDst          = w_ctrl.reg_dst;
   assign ALUSrc          = w_ctrl.alu_src;
   assign ALUOp           = w_ctrl.alu_op;
   assign MemtoReg        = w_ctrl.mem_to_reg;
   assign illegal         = w_ctrl.illegal;
   assign halted          = w_ctrl.halted;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench for mips_control_fsm. The stimulus process drives one
// cycle at a time and queues the hand-derived expected outputs for that
// cycle; the monitor pops and compares mid-cycle. An 8-bit counter keeps the
// wrap test short.
module tb_mips_control_fsm;
   localparam int CW = 8;

   localparam logic [5:0] S_HALT = 6'b000000, S_IF = 6'b000001, S_ID = 6'b000010,
                          S_EX = 6'b000100, S_MEMW = 6'b001000, S_MEMR = 6'b010000,
                          S_WB = 6'b100000;
   localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                          O_BEQ = 6'b000100, O_J = 6'b000010, O_ADDI = 6'b001000,
                          O_HALT = 6'b111111, O_BAD = 6'b110011;

   // Strobe bit positions in the observed 16-bit vector
   localparam logic [15:0] F_REQ = 16'h8000, F_RD = 16'h4000, F_WR = 16'h2000,
                           F_IRW = 16'h1000, F_PCW = 16'h0800, F_PCC = 16'h0400,
                           F_SRC_J = 16'h0200, F_SRC_BR = 16'h0100, F_RW = 16'h0080,
                           F_RDST = 16'h0040, F_ASRC = 16'h0020, F_ALU_FN = 16'h0010,
                           F_ALU_SUB = 16'h0008, F_M2R = 16'h0004, F_ILL = 16'h0002,
                           F_HALT = 16'h0001;
   localparam logic [15:0] E_IFW  = 16'hC000;  // fetch waiting
   localparam logic [15:0] E_IFGO = 16'hD800;  // fetch completing

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    opcode;
   logic          zero;
   logic [5:0]    state;
   logic          RegWrite, RegDst, ALUSrc, MemtoReg, IRWrite, PCWrite, PCWriteCond;
   logic          illegal, halted;
   logic [1:0]    ALUOp, PCSrc;
   logic [CW-1:0] retired;
   logic [15:0]   obs;

   mips_control_fsm_if mif ();

   mips_control_fsm #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_if(mif),
      .state(state), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrc(ALUSrc),
      .ALUOp(ALUOp), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCWriteCond(PCWriteCond), .PCSrc(PCSrc), .illegal(illegal),
      .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   assign obs = {mif.mem_req, mif.MemRead, mif.MemWrite, IRWrite, PCWrite, PCWriteCond,
                 PCSrc, RegWrite, RegDst, ALUSrc, ALUOp, MemtoReg, illegal, halted};

   typedef struct {
      logic [5:0]    st;
      logic [15:0]   strb;
      logic [CW-1:0] ret;
      int            idx;
   } exp_t;

   exp_t          exp_q[$];
   int            checks = 0;
   int            failures = 0;
   int            cyc_n = 0;
   logic [CW-1:0] exp_ret = '0;

   // Monitor: every cycle with a queued expectation is one transaction
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (state !== e.st) begin
               failures++;
               $display("FAIL state cyc=%0d got=%b exp=%b", e.idx, state, e.st);
            end
            checks++;
            if (obs !== e.strb) begin
               failures++;
               $display("FAIL strobes cyc=%0d state=%b got=%h exp=%h", e.idx, state, obs, e.strb);
            end
            checks++;
            if (retired !== e.ret) begin
               failures++;
               $display("FAIL retired cyc=%0d got=%0d exp=%0d", e.idx, retired, e.ret);
            end
         end
      end
   end

   // One normal cycle: drive inputs, queue the expectation, advance
   task automatic cyc(input logic [5:0] op, input logic rdy, input logic [5:0] st,
                      input logic [15:0] strb);
      rst_n = 1'b1;
      opcode = op;
      mif.mem_ready = rdy;
      exp_q.push_back('{st, strb, exp_ret, cyc_n});
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   // One cycle with reset asserted (outputs still reflect the old phase)
   task automatic rst_cyc(input logic [5:0] st, input logic [15:0] strb);
      rst_n = 1'b0;
      mif.mem_ready = 1'b1;
      exp_q.push_back('{st, strb, exp_ret, cyc_n});
      @(posedge clk);
      #1;
      cyc_n++;
      exp_ret = '0;
   endtask

   // One complete instruction with hand-derived per-cycle expectations.
   // late_op is presented from EX onward to show it is ignored.
   task automatic run_instr(input logic [5:0] op, input int if_wait, input int mem_wait,
                            input logic idle_rdy, input logic z, input logic [5:0] late_op,
                            input bit verbose);
      if (verbose)
         $display("instr op=%b if_wait=%0d mem_wait=%0d zero=%b retired_before=%0d",
                  op, if_wait, mem_wait, z, exp_ret);
      zero = z;
      for (int i = 0; i < if_wait; i++) cyc(op, 1'b0, S_IF, E_IFW);
      cyc(op, 1'b1, S_IF, E_IFGO);
      case (op)
         O_J: begin
            cyc(op, idle_rdy, S_ID, F_PCW | F_SRC_J);
            exp_ret++;
         end
         O_R: begin
            cyc(op, idle_rdy, S_ID, 16'h0000);
            cyc(late_op, idle_rdy, S_EX, F_ALU_FN);
            cyc(late_op, idle_rdy, S_WB, F_RW | F_RDST);
            exp_ret++;
         end
         O_ADDI: begin
            cyc(op, idle_rdy, S_ID, 16'h0000);
            cyc(late_op, idle_rdy, S_EX, F_ASRC);
            cyc(late_op, idle_rdy, S_WB, F_RW);
            exp_ret++;
         end
         O_LW: begin
            cyc(op, idle_rdy, S_ID, 16'h0000);
            cyc(late_op, idle_rdy, S_EX, F_ASRC);
            for (int i = 0; i < mem_wait; i++) cyc(late_op, 1'b0, S_MEMR, F_REQ | F_RD);
            cyc(late_op, 1'b1, S_MEMR, F_REQ | F_RD);
            cyc(late_op, idle_rdy, S_WB, F_RW | F_M2R);
            exp_ret++;
         end
         O_SW: begin
            cyc(op, idle_rdy, S_ID, 16'h0000);
            cyc(late_op, idle_rdy, S_EX, F_ASRC);
            for (int i = 0; i < mem_wait; i++) cyc(late_op, 1'b0, S_MEMW, F_REQ | F_WR);
            cyc(late_op, 1'b1, S_MEMW, F_REQ | F_WR);
            exp_ret++;
         end
         O_BEQ: begin
            cyc(op, idle_rdy, S_ID, 16'h0000);
            cyc(late_op, idle_rdy, S_EX, F_ALU_SUB | F_PCC | F_SRC_BR);
            exp_ret++;
         end
         O_HALT: begin
            cyc(op, idle_rdy, S_ID, 16'h0000);
            for (int i = 0; i < 6; i++)
               cyc((i % 2 == 0) ? O_R : O_J, i[0], S_HALT, F_HALT);
         end
         default: cyc(op, idle_rdy, S_ID, F_ILL);
      endcase
   endtask

   initial begin
      rst_n = 1'b0;
      opcode = O_R;
      zero = 1'b0;
      mif.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      run_instr(O_R,    0, 0, 1'b1, 1'b0, O_R,    1);
      run_instr(O_LW,   2, 3, 1'b1, 1'b0, O_LW,   1);
      run_instr(O_ADDI, 0, 0, 1'b0, 1'b0, O_ADDI, 1);
      run_instr(O_SW,   1, 2, 1'b0, 1'b0, O_SW,   1);
      run_instr(O_BEQ,  0, 0, 1'b1, 1'b1, O_BEQ,  1);
      run_instr(O_BEQ,  0, 0, 1'b0, 1'b0, O_R,    1);
      run_instr(O_R,    0, 0, 1'b1, 1'b0, O_LW,   1);
      run_instr(O_J,    1, 0, 1'b1, 1'b0, O_J,    1);
      run_instr(O_BAD,  0, 0, 1'b1, 1'b0, O_BAD,  1);
      run_instr(O_ADDI, 0, 0, 1'b1, 1'b0, O_ADDI, 1);
      run_instr(O_HALT, 0, 0, 1'b1, 1'b0, O_HALT, 1);
      $display("reset from HALT");
      rst_cyc(S_HALT, F_HALT);

      // Bring the counter to all-ones, then reset in the middle of a store
      $display("running %0d j instructions", (1 << CW) - 1);
      for (int k = 0; k < (1 << CW) - 1; k++) run_instr(O_J, 0, 0, 1'b1, 1'b0, O_J, 0);
      $display("sw aborted by reset during MEMW, retired_before=%0d", exp_ret);
      zero = 1'b0;
      cyc(O_SW, 1'b1, S_IF, E_IFGO);
      cyc(O_SW, 1'b1, S_ID, 16'h0000);
      cyc(O_SW, 1'b1, S_EX, F_ASRC);
      cyc(O_SW, 1'b0, S_MEMW, F_REQ | F_WR);
      rst_cyc(S_MEMW, F_REQ | F_WR);

      // Separate run: fill the counter again and wrap it with one more j
      $display("running %0d j instructions", (1 << CW) - 1);
      for (int k = 0; k < (1 << CW) - 1; k++) run_instr(O_J, 0, 0, 1'b1, 1'b0, O_J, 0);
      run_instr(O_J, 0, 0, 1'b1, 1'b0, O_J, 1);
      run_instr(O_R, 0, 0, 1'b1, 1'b0, O_R, 1);

      // Every queued expectation must have been consumed by the monitor
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_control_fsm.md
# mips_control_fsm

Multi-cycle control sequencer for the non-pipelined MIPS core. It generates the one-hot `state` bus that gates register-file reads in decode and writes in writeback, plus every datapath control strobe. It is the initiating end of the register-file `state`/`RegWrite` protocol. It also handshakes with instruction/data memory and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-low.
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `opcode` input, 6 bits: IR[31:26]; valid from ID onward.
- `zero` input, 1 bit: ALU zero flag; valid in EX.
- `mem_ready` input, 1 bit: memory completes the current request this cycle.
- `state` output, 6 bits: one-hot phase; the register file reads when this is 000010 and writes when it is 100000.
- `RegWrite` output, 1 bit: register-file write enable.
- `RegDst` output, 1 bit: destination select; 1 selects rd, 0 selects rt.
- `ALUSrc` output, 1 bit: ALU B operand; 1 selects the sign-extended immediate, 0 selects the register.
- `ALUOp` output, 2 bits: 00 add, 01 sub, 10 funct-decoded.
- `MemtoReg` output, 1 bit: writeback source; 1 selects memory data, 0 selects the ALU result.
- `mem_req` output, 1 bit: memory request.
- `MemRead` output, 1 bit: memory read.
- `MemWrite` output, 1 bit: memory write.
- `IRWrite` output, 1 bit: load the IR.
- `PCWrite` output, 1 bit: unconditional PC update.
- `PCWriteCond` output, 1 bit: PC update, gated by `zero`.
- `PCSrc` output, 2 bits: 00 PC+4, 01 branch target, 10 jump target.
- `illegal` output, 1 bit: one-cycle pulse on an undefined opcode.
- `halted` output, 1 bit: the core is halted.
- `retired` output, CNT_W bits: count of completed instructions.

## Operation
- State encodings:
  - IF 000001
  - ID 000010
  - EX 000100
  - MEMW 001000
  - MEMR 010000
  - WB 100000
  - HALT 000000
- Outputs are Moore-decoded from the registered state and the opcode latched on entry to EX (`op_q`). Exception: in ID the outputs use `opcode` directly.
- Transitions:
  - IF: `mem_req`=`MemRead`=1. Stay in IF while `mem_ready`=0. On `mem_ready`=1, assert `IRWrite`=1 and `PCWrite`=1 (`PCSrc`=00), then go to ID.
  - ID, R-type (000000), lw (100011), sw (101011), beq (000100), addi (001000): go to EX.
  - ID, j (000010): `PCWrite`=1, `PCSrc`=10; retire; go to IF.
  - ID, halt (111111): go to HALT.
  - ID, any other opcode: pulse `illegal`; go to IF with no write and no retire.
  - EX, R-type: `ALUOp`=10; go to WB.
  - EX, addi, lw, sw: `ALUSrc`=1, `ALUOp`=00. addi goes to WB, lw goes to MEMR, sw goes to MEMW.
  - EX, beq: `ALUOp`=01, `PCWriteCond`=1, `PCSrc`=01; retire; go to IF.
  - MEMR: `mem_req`=`MemRead`=1. Stay while `mem_ready`=0; on `mem_ready`=1 go to WB.
  - MEMW: `mem_req`=`MemWrite`=1. Stay while `mem_ready`=0; on `mem_ready`=1, retire and go to IF.
  - WB: `RegWrite`=1. `RegDst`=1 only for R-type. `MemtoReg`=1 only for lw. Retire; go to IF.
  - HALT: all strobes are 0 and `halted`=1. The FSM stays in HALT until reset.
- Retire increments `retired` by 1 and wraps modulo 2^CNT_W.
- Strobes not listed for a state are 0.

## Timing
- Reset (`rst_n`=0 at an edge) forces, on the next cycle:
  - `state`=IF; `op_q`=0; `retired`=0.
  - `halted`=0 and `illegal`=0.
  - Strobes decode for IF, so `mem_req`=`MemRead`=1 immediately.
- Reset mid-instruction (including during a memory wait or HALT) aborts the instruction with no retire. Any pending memory request is dropped.
- `RegWrite` is high for exactly one cycle per writing instruction and only while `state`=WB. It is never high in any other state.
- `state` is exactly one-hot in every non-HALT cycle.
- Latency with `mem_ready` tied high:

  | Instruction | Cycles |
  |---|---|
  | j | 2 |
  | beq | 3 |
  | R-type, addi, sw | 4 |
  | lw | 5 |

  Each wait cycle with `mem_ready`=0 in IF, MEMR or MEMW adds one cycle.
- `IRWrite` and `PCWrite` in IF are asserted only in the cycle where `mem_ready`=1.
- `mem_ready` is ignored outside IF, MEMR and MEMW.
- A change in `opcode` after EX entry has no effect, because decisions use `op_q`.

## Structure
- Package `mips_ctrl_pkg` holds:
  - state localparams (IF, ID, EX, MEMW, MEMR, WB, HALT);
  - opcode constants (RTYPE, LW, SW, BEQ, J, ADDI, HALT_OP);
  - ALUOp codes;
  - PCSrc codes.
  The register file imports the ID and WB encodings from this package.
- The block has one sub-module, `mips_ctrl_decode`. It is combinational and maps (state, opcode) to the strobe vector.
- Next-state logic, `op_q` and the retire counter stay in `mips_control_fsm`.

## Test plan
- Reset, then an R-type instruction with `mem_ready`=1:
  - `state` sequence is 000001, 000010, 000100, 100000, 000001.
  - `RegWrite`=1 and `RegDst`=1 only in WB.
  - `retired`=1.
- lw with `mem_ready` low for 2 cycles in IF and 3 cycles in MEMR:
  - 10 cycles total.
  - `MemtoReg`=1 in WB.
  - `IRWrite` is a single pulse.
- beq:
  - with `zero`=1, `PCWriteCond`=1 and `PCSrc`=01 in EX, and the FSM returns to IF;
  - with `zero`=0, the same strobes;
  - `RegWrite` is never 1.
- Opcode 110011:
  - `illegal` pulses in ID, then IF.
  - `retired` is unchanged.
  - Then opcode 111111 gives `halted`=1 and `state`=000000 indefinitely.
- `rst_n`=0 asserted during MEMW, and `retired` preset to 0xFFFF by running 65535 j instructions:
  - Reset returns `state` to IF and `retired` to 0.
  - In a separate run without reset, one more j wraps `retired` to 0x0000.
